// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - program counter and fetch control with optional return-address stack
// Optional feature macro: FETCH_CTRL_RAS_EN (defined builds the RAS; undefined makes call = branch, ret = increment)
module fetch_ctrl #(
    parameter int PC_W       = 8,
    parameter int TGT_W      = 8,
    parameter int START_ADDR = 0,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                           CLK,
    input  logic                           start,
    input  logic                           halt,
    input  logic                           stall,
    input  logic                           branch,
    input  logic                           abs_mode,
    input  logic                           call,
    input  logic                           ret,
    input  logic [TGT_W-1:0]               target,
    output logic [PC_W-1:0]                PC,
    output logic                           halted,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_ovf,
    output logic                           ras_unf
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // The single action chosen this cycle; the RAS logic keys off it too.
    typedef enum logic [2:0] {
        ACT_RESET  = 3'd0,
        ACT_HOLD   = 3'd1,
        ACT_RET    = 3'd2,
        ACT_CALL   = 3'd3,
        ACT_BRANCH = 3'd4,
        ACT_INC    = 3'd5
    } act_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    act_t            act;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] tgt_zext;
    logic [PC_W-1:0] tgt_sext;
    logic [PC_W-1:0] branch_pc;
    logic            ras_empty;
    logic [PC_W-1:0] ras_top;

    assign pc_inc    = pc_q + PC_W'(1);
    assign tgt_zext  = PC_W'(target);
    assign tgt_sext  = PC_W'($signed(target));
    assign branch_pc = abs_mode ? tgt_zext : (pc_q + tgt_sext);

    // State register for the run/halt FSM and the program counter.
    always_ff @(posedge CLK) begin
        if (start) begin
            state_q <= ST_RUN;
            pc_q    <= START_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Priority decode of the controls into one action, plus next PC and state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        act     = ACT_INC;
        if (start) begin
            act     = ACT_RESET;
            state_d = ST_RUN;
            pc_d    = START_PC;
        end else if ((state_q == ST_HALT) || halt) begin
            act     = ACT_HOLD;
            state_d = ST_HALT;
        end else if (stall) begin
            act = ACT_HOLD;
        end else if (ret) begin
            act  = ACT_RET;
            // An empty stack (or no stack at all) falls through to the next address.
            pc_d = ras_empty ? pc_inc : ras_top;
        end else if (call) begin
            act  = ACT_CALL;
            pc_d = branch_pc;
        end else if (branch) begin
            act  = ACT_BRANCH;
            pc_d = branch_pc;
        end else begin
            act  = ACT_INC;
            pc_d = pc_inc;
        end
    end

    assign PC     = pc_q;
    assign halted = (state_q == ST_HALT);

`ifdef FETCH_CTRL_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    // Circular buffer: ptr_q is the next write slot, the top lives one behind it.
    // A push when full simply overwrites the oldest entry.
    logic [PC_W-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q;
    logic            unf_q;

    assign ptr_inc   = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : (ptr_q + PW'(1));
    assign ptr_dec   = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : (ptr_q - PW'(1));
    assign ras_empty = (cnt_q == '0);
    assign ras_top   = ras_q[ptr_dec];

    // Stack bookkeeping: pointer, occupancy and the sticky overflow/underflow flags.
    always_ff @(posedge CLK) begin
        if (act == ACT_RESET) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (act == ACT_CALL) begin
            ptr_q <= ptr_inc;
            if (cnt_q == CW'(RAS_DEPTH)) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (act == ACT_RET) begin
            if (cnt_q == '0) begin
                unf_q <= 1'b1;
            end else begin
                ptr_q <= ptr_dec;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    // Return-address storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (act == ACT_CALL) begin
            ras_q[ptr_q] <= pc_inc;
        end
    end

    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;
`else
    assign ras_empty = 1'b1;
    assign ras_top   = '0;
    assign ras_count = '0;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized and directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam int PC_W   = 8;
    localparam int TGT_W  = 8;
    localparam int START  = 16;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int PCMASK = (1 << PC_W) - 1;

    logic             CLK = 1'b0;
    logic             start = 1'b1;
    logic             halt = 1'b0;
    logic             stall = 1'b0;
    logic             branch = 1'b0;
    logic             abs_mode = 1'b0;
    logic             call = 1'b0;
    logic             ret = 1'b0;
    logic [TGT_W-1:0] target = '0;
    logic [PC_W-1:0]  PC;
    logic             halted;
    logic [CW-1:0]    ras_count;
    logic             ras_ovf;
    logic             ras_unf;

    always #5 CLK = ~CLK;

    fetch_ctrl #(
        .PC_W      (PC_W),
        .TGT_W     (TGT_W),
        .START_ADDR(START),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .CLK      (CLK),
        .start    (start),
        .halt     (halt),
        .stall    (stall),
        .branch   (branch),
        .abs_mode (abs_mode),
        .call     (call),
        .ret      (ret),
        .target   (target),
        .PC       (PC),
        .halted   (halted),
        .ras_count(ras_count),
        .ras_ovf  (ras_ovf),
        .ras_unf  (ras_unf)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_pc     = START;
    bit m_halted = 1'b0;
    bit m_ovf    = 1'b0;
    bit m_unf    = 1'b0;
    int m_ras[$];
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int tgt_of(input int pc, input bit am, input int t);
        int off;
        if (am) return t;
        off = (t >= (1 << (TGT_W - 1))) ? t - (1 << TGT_W) : t;
        return (pc + off) & PCMASK;
    endfunction

    // Apply one cycle of the architectural rules to the model.
    task automatic model_step();
        int t;
        t = int'(target);
        if (start) begin
            m_pc = START; m_halted = 0; m_ovf = 0; m_unf = 0;
            m_ras.delete();
        end else if (m_halted || halt) begin
            m_halted = 1;
        end else if (stall) begin
            // hold
        end else if (ret) begin
`ifdef FETCH_CTRL_RAS_EN
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = (m_pc + 1) & PCMASK; m_unf = 1; end
`else
            m_pc = (m_pc + 1) & PCMASK;
`endif
        end else if (call) begin
`ifdef FETCH_CTRL_RAS_EN
            m_ras.push_back((m_pc + 1) & PCMASK);
            if (m_ras.size() > DEPTH) begin
                void'(m_ras.pop_front());
                m_ovf = 1;
            end
`endif
            m_pc = tgt_of(m_pc, abs_mode, t);
        end else if (branch) begin
            m_pc = tgt_of(m_pc, abs_mode, t);
        end else begin
            m_pc = (m_pc + 1) & PCMASK;
        end
    endtask

    // Every-cycle comparison of DUT against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("pc", 32'(PC), 32'(m_pc));
            check("halted", 32'(halted), 32'(m_halted));
            check("ras_count", 32'(ras_count), 32'(m_ras.size()));
            check("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
            check("ras_unf", 32'(ras_unf), 32'(m_unf));
        end
    end

    task automatic cyc(input bit st, input bit h, input bit s, input bit b,
                       input bit am, input bit c, input bit r, input int t);
        start = st; halt = h; stall = s; branch = b;
        abs_mode = am; call = c; ret = r; target = TGT_W'(t);
        @(posedge CLK);
        model_step();
        #1;
        chk_en = 1'b1;
    endtask

    task automatic idle();        cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic rst();         cyc(1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic jump(input int a);     cyc(0, 0, 0, 1, 1, 0, 0, a); endtask
    task automatic call_abs(input int a); cyc(0, 0, 0, 0, 1, 1, 0, a); endtask
    task automatic do_ret();      cyc(0, 0, 0, 0, 0, 0, 1, 0); endtask

    initial begin
        // Reset and increment
        rst();  check("lit_rst1_pc", 32'(PC), 32'h10);
        check("lit_rst_halted", 32'(halted), 32'h0);
        check("lit_rst_cnt", 32'(ras_count), 32'h0);
        rst();  check("lit_rst2_pc", 32'(PC), 32'h10);
        idle(); check("lit_inc1", 32'(PC), 32'h11);
        idle(); check("lit_inc2", 32'(PC), 32'h12);
        idle(); check("lit_inc3", 32'(PC), 32'h13);
        jump(8'hFF); check("lit_abs_ff", 32'(PC), 32'hFF);
        idle(); check("lit_wrap", 32'(PC), 32'h00);

        // Relative and absolute branch
        jump(8'h20);
        cyc(0, 0, 0, 1, 0, 0, 0, 8'hFC); check("lit_rel_neg", 32'(PC), 32'h1C);
        cyc(0, 0, 0, 1, 1, 0, 0, 8'h05); check("lit_abs", 32'(PC), 32'h05);

`ifdef FETCH_CTRL_RAS_EN
        // Nesting
        jump(8'h10);
        call_abs(8'h40); check("lit_call1", 32'(PC), 32'h40);
        call_abs(8'h60); check("lit_call2_cnt", 32'(ras_count), 32'h2);
        do_ret(); check("lit_ret1", 32'(PC), 32'h41);
        do_ret(); check("lit_ret2", 32'(PC), 32'h11);
        check("lit_nest_cnt", 32'(ras_count), 32'h0);
        check("lit_nest_flags", 32'({ras_ovf, ras_unf}), 32'h0);

        // Overflow then underflow
        jump(8'h10);
        for (int i = 0; i < 5; i++) call_abs(8'h20 + 16 * i);
        check("lit_ovf", 32'(ras_ovf), 32'h1);
        check("lit_ovf_cnt", 32'(ras_count), 32'h4);
        do_ret(); check("lit_pop_51", 32'(PC), 32'h51);
        do_ret(); check("lit_pop_41", 32'(PC), 32'h41);
        do_ret(); check("lit_pop_31", 32'(PC), 32'h31);
        do_ret(); check("lit_pop_21", 32'(PC), 32'h21);
        check("lit_unf_before", 32'(ras_unf), 32'h0);
        do_ret(); check("lit_unf_pc", 32'(PC), 32'h22);
        check("lit_unf", 32'(ras_unf), 32'h1);

        // Reset mid call chain empties the stack
        rst();
        check("lit_flags_clr", 32'({ras_ovf, ras_unf}), 32'h0);
        call_abs(8'h40); rst();
        do_ret(); check("lit_post_rst_unf", 32'(ras_unf), 32'h1);
        check("lit_post_rst_pc", 32'(PC), 32'h11);
        rst();
`else
        // Without a stack call is a branch and ret an increment
        jump(8'h10);
        cyc(0, 0, 0, 0, 0, 1, 0, 8'h04); check("lit_call_rel", 32'(PC), 32'h14);
        do_ret(); check("lit_ret_inc", 32'(PC), 32'h15);
        check("lit_off_cnt", 32'(ras_count), 32'h0);
        check("lit_off_flags", 32'({ras_ovf, ras_unf}), 32'h0);
`endif

        // Stall, halt and priority
        jump(8'h30);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
        check("lit_stall_pc", 32'(PC), 32'h30);
        check("lit_stall_halted", 32'(halted), 32'h0);
        cyc(0, 1, 0, 1, 1, 0, 0, 8'h77);
        check("lit_halt_pc", 32'(PC), 32'h30);
        check("lit_halt", 32'(halted), 32'h1);
        cyc(0, 0, 0, 1, 1, 0, 0, 8'h77);
        cyc(0, 0, 0, 0, 1, 1, 0, 8'h55);
        check("lit_halt_frozen", 32'(PC), 32'h30);
        check("lit_halt_cnt", 32'(ras_count), 32'h0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        check("lit_unhalt_pc", 32'(PC), 32'h10);
        check("lit_unhalt", 32'(halted), 32'h0);

        // Randomized traffic checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 30,
                1'($urandom_range(0, 1)), $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 25, int'($urandom_range(0, 255)));
        end

        @(negedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
